// File: rtl/vdp_pkg.sv
// Shared constants and types for the VDP CPU host port.
// Port decode, register-select marker, status layout and FSM states.
package vdp_pkg;

    localparam logic [1:0] PORT_DATA    = 2'b00;
    localparam logic [1:0] PORT_ADDR_LO = 2'b01;
    localparam logic [1:0] PORT_ADDR_HI = 2'b10;
    localparam logic [1:0] PORT_REG     = 2'b11;

    localparam logic [4:0] REG_SELECT = 5'b10000;

    localparam int ST_FULL  = 7;
    localparam int ST_EMPTY = 6;
    localparam int ST_PEND  = 5;
    localparam int ST_OVR   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ_REQ,
        S_READ_WAIT
    } state_e;

endpackage

// File: rtl/vdp_write_fifo.sv
// Synchronous write queue for VRAM writes; exposes head and the entry
// behind it so the port can keep ramReq high across back-to-back grants.
module vdp_write_fifo #(
    parameter int Depth = 4,
    parameter int Width = 24
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         head_o,
    output logic [Width-1:0]         next_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    rdPtr_q, wrPtr_q;
    logic [AW-1:0]    rdNext;
    logic [CW-1:0]    count_q;

    assign rdNext  = rdPtr_q + 1'b1;
    assign head_o  = mem_q[rdPtr_q];
    assign next_o  = mem_q[rdNext];
    assign full_o  = (count_q == CW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wrPtr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop_i)  rdPtr_q <= rdNext;
            unique case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vdp_host_port.sv
// CPU host port of the VDP: address pointer, queued VRAM writes,
// read prefetch and the two-byte register write sequencer.
module vdp_host_port
    import vdp_pkg::*;
#(
    parameter int RamBits   = 16,
    parameter int FifoDepth = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         cpuAddr,
    input  logic               cpuWr,
    input  logic               cpuRd,
    input  logic [7:0]         cpuDataIn,
    output logic [7:0]         cpuDataOut,
    output logic               cpuBusy,
    output logic               ramReq,
    output logic               ramWe,
    output logic [RamBits-1:0] ramAddr,
    output logic [7:0]         ramWData,
    input  logic               ramGrant,
    input  logic [7:0]         ramRData,
    output logic               regWe,
    output logic [2:0]         regIdx,
    output logic [7:0]         regData
);

    localparam int EW = RamBits + 8;
    localparam int HW = RamBits - 8;
    localparam int CW = $clog2(FifoDepth) + 1;

    state_e state_q, state_d;

    logic [RamBits-1:0] addrPtr_q, addrPtr_d;
    logic [RamBits-1:0] ramAddr_q, ramAddr_d;
    logic [7:0] ramWData_q, ramWData_d;
    logic [7:0] readBuf_q, readBuf_d;
    logic [7:0] cpuDataOut_q, cpuDataOut_d;
    logic [7:0] regLatch_q, regLatch_d;
    logic [7:0] regData_q, regData_d;
    logic [2:0] regIdx_q, regIdx_d;
    logic regWe_q, regWe_d;
    logic regToggle_q, regToggle_d;
    logic overrun_q, overrun_d;
    logic rdPend_q, rdPend_d;
    logic ramReq_q, ramReq_d;
    logic ramWe_q, ramWe_d;

    logic          fifoPush, fifoPop, fifoFull, fifoEmpty;
    logic [EW-1:0] fifoWData, fifoHead, fifoNext;
    logic [CW-1:0] fifoCount;

    logic       readPending, busy, wrOk, rdOk, trig, issue;
    logic [7:0] status;

    vdp_write_fifo #(
        .Depth (FifoDepth),
        .Width (EW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .wdata_i (fifoWData),
        .head_o  (fifoHead),
        .next_o  (fifoNext),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    assign readPending = rdPend_q | (state_q == S_READ_REQ)
                                  | (state_q == S_READ_WAIT);
    assign busy  = fifoFull | readPending;
    assign wrOk  = cpuWr & ~busy;
    assign rdOk  = cpuRd & (~busy | (cpuAddr == PORT_REG));
    assign issue = (state_q == S_IDLE) & fifoEmpty & rdPend_q;
    assign fifoWData = {addrPtr_q, cpuDataIn};

    always_comb begin
        status           = '0;
        status[ST_FULL]  = fifoFull;
        status[ST_EMPTY] = fifoEmpty;
        status[ST_PEND]  = readPending;
        status[ST_OVR]   = overrun_q;
    end

    always_comb begin
        addrPtr_d    = addrPtr_q;
        cpuDataOut_d = cpuDataOut_q;
        regLatch_d   = regLatch_q;
        regToggle_d  = regToggle_q;
        regIdx_d     = regIdx_q;
        regData_d    = regData_q;
        regWe_d      = 1'b0;
        overrun_d    = overrun_q;
        fifoPush     = 1'b0;
        trig         = 1'b0;
        if ((cpuWr | cpuRd) & busy & ~(cpuRd & (cpuAddr == PORT_REG)))
            overrun_d = 1'b1;
        if (wrOk) begin
            unique case (cpuAddr)
                PORT_DATA: begin
                    fifoPush  = 1'b1;
                    addrPtr_d = addrPtr_q + 1'b1;
                end
                PORT_ADDR_LO: begin
                    addrPtr_d[7:0] = cpuDataIn;
                    regToggle_d    = 1'b0;
                end
                PORT_ADDR_HI: begin
                    addrPtr_d[RamBits-1:8] = cpuDataIn[HW-1:0];
                    regToggle_d = 1'b0;
                    trig        = 1'b1;
                end
                PORT_REG: begin
                    regToggle_d = ~regToggle_q;
                    if (!regToggle_q) begin
                        regLatch_d = cpuDataIn;
                    end else if (cpuDataIn[7:3] == REG_SELECT) begin
                        regWe_d   = 1'b1;
                        regIdx_d  = cpuDataIn[2:0];
                        regData_d = regLatch_q;
                    end
                end
            endcase
        end else if (rdOk) begin
            if (cpuAddr == PORT_DATA) begin
                cpuDataOut_d = readBuf_q;
                addrPtr_d    = addrPtr_q + 1'b1;
                trig         = 1'b1;
            end else if (cpuAddr == PORT_REG) begin
                cpuDataOut_d = status;
                overrun_d    = 1'b0;
                regToggle_d  = 1'b0;
            end
        end
        rdPend_d = (rdPend_q & ~issue) | trig;
    end

    // Queued writes always drain before a prefetch is issued.
    always_comb begin
        state_d    = state_q;
        ramReq_d   = 1'b0;
        ramWe_d    = 1'b0;
        ramAddr_d  = ramAddr_q;
        ramWData_d = ramWData_q;
        readBuf_d  = readBuf_q;
        fifoPop    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifoEmpty) begin
                    state_d  = S_WRITE;
                    ramReq_d = 1'b1;
                    ramWe_d  = 1'b1;
                    {ramAddr_d, ramWData_d} = fifoHead;
                end else if (rdPend_q) begin
                    state_d   = S_READ_REQ;
                    ramReq_d  = 1'b1;
                    ramAddr_d = addrPtr_q;
                end
            end
            S_WRITE: begin
                ramReq_d = 1'b1;
                ramWe_d  = 1'b1;
                if (ramGrant) begin
                    fifoPop = 1'b1;
                    if (fifoCount > CW'(1)) begin
                        {ramAddr_d, ramWData_d} = fifoNext;
                    end else if (fifoPush) begin
                        {ramAddr_d, ramWData_d} = fifoWData;
                    end else begin
                        state_d  = S_IDLE;
                        ramReq_d = 1'b0;
                        ramWe_d  = 1'b0;
                    end
                end
            end
            S_READ_REQ: begin
                ramReq_d = 1'b1;
                if (ramGrant) begin
                    state_d  = S_READ_WAIT;
                    ramReq_d = 1'b0;
                end
            end
            S_READ_WAIT: begin
                readBuf_d = ramRData;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            addrPtr_q    <= '0;
            ramAddr_q    <= '0;
            ramWData_q   <= '0;
            readBuf_q    <= '0;
            cpuDataOut_q <= '0;
            regLatch_q   <= '0;
            regData_q    <= '0;
            regIdx_q     <= '0;
            regWe_q      <= 1'b0;
            regToggle_q  <= 1'b0;
            overrun_q    <= 1'b0;
            rdPend_q     <= 1'b0;
            ramReq_q     <= 1'b0;
            ramWe_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addrPtr_q    <= addrPtr_d;
            ramAddr_q    <= ramAddr_d;
            ramWData_q   <= ramWData_d;
            readBuf_q    <= readBuf_d;
            cpuDataOut_q <= cpuDataOut_d;
            regLatch_q   <= regLatch_d;
            regData_q    <= regData_d;
            regIdx_q     <= regIdx_d;
            regWe_q      <= regWe_d;
            regToggle_q  <= regToggle_d;
            overrun_q    <= overrun_d;
            rdPend_q     <= rdPend_d;
            ramReq_q     <= ramReq_d;
            ramWe_q      <= ramWe_d;
        end
    end

    assign cpuDataOut = cpuDataOut_q;
    assign cpuBusy    = busy;
    assign ramReq     = ramReq_q;
    assign ramWe      = ramWe_q;
    assign ramAddr    = ramAddr_q;
    assign ramWData   = ramWData_q;
    assign regWe      = regWe_q;
    assign regIdx     = regIdx_q;
    assign regData    = regData_q;

endmodule
